// File: rtl/step_key_conditioner_pkg.sv
// Shared state encoding and 50 MHz board timing defaults for the step key conditioner.
package step_key_conditioner_pkg;

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_DN_WAIT = 2'd1,
        S_DOWN    = 2'd2,
        S_UP_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1000000;
    localparam int unsigned RUN_DIV_50MHZ         = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/step_key_conditioner.sv
// Turns a bouncy step key and a run switch into a clean one-cycle CPU step strobe,
// with a free-running auto-step mode and a wrapping step counter.
module step_key_conditioner
    import step_key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int unsigned RUN_DIV         = RUN_DIV_50MHZ,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_ni,
    input  logic             sw_run_i,
    output logic             step_pulse_o,
    output logic             key_level_o,
    output logic             run_mode_o,
    output logic [CNT_W-1:0] step_count_o
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DivW = $clog2(RUN_DIV);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);

    logic key_sync_n;
    logic run_s;
    logic key_s;

    // Key idles released (high) out of reset so no phantom press is seen.
    sync_2ff #(.RESET_VAL(1'b1)) u_key_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (key_ni),
        .q_o    (key_sync_n)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_run_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sw_run_i),
        .q_o    (run_s)
    );

    assign key_s = ~key_sync_n;

    key_state_e       state_q, state_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             step_pulse_q, key_level_q;
    logic [CNT_W-1:0] step_count_q;
    logic             press_done;
    logic             auto_fire;

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        press_done = 1'b0;
        unique case (state_q)
            S_UP: begin
                if (key_s) begin
                    state_d  = S_DN_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_DN_WAIT: begin
                if (!key_s) begin
                    state_d = S_UP;
                end else if (db_cnt_q == DbLast) begin
                    state_d    = S_DOWN;
                    press_done = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            S_DOWN: begin
                if (!key_s) begin
                    state_d  = S_UP_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_UP_WAIT: begin
                if (key_s) begin
                    state_d = S_DOWN;
                end else if (db_cnt_q == DbLast) begin
                    state_d = S_UP;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            default: state_d = S_UP;
        endcase
    end

    // Divider only runs while run mode is synchronized high; dropping out clears it.
    always_comb begin
        div_d     = '0;
        auto_fire = 1'b0;
        if (run_s) begin
            if (div_q == DivLast) begin
                auto_fire = 1'b1;
            end else begin
                div_d = div_q + DivW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_UP;
            db_cnt_q     <= '0;
            div_q        <= '0;
            step_pulse_q <= 1'b0;
            key_level_q  <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            div_q        <= div_d;
            step_pulse_q <= auto_fire | (press_done & ~run_s);
            key_level_q  <= (state_d == S_DOWN) || (state_d == S_UP_WAIT);
            step_count_q <= step_count_q + CNT_W'(step_pulse_q);
        end
    end

    assign step_pulse_o = step_pulse_q;
    assign key_level_o  = key_level_q;
    assign run_mode_o   = run_s;
    assign step_count_o = step_count_q;

endmodule

// File: tb/tb_step_key_conditioner.sv
// Directed bench for step_key_conditioner with short debounce and divider settings.
module tb_step_key_conditioner;

    localparam int unsigned CntW = 4;

    logic            clk_i    = 1'b0;
    logic            rst_ni   = 1'b1;
    logic            key_ni   = 1'b1;
    logic            sw_run_i = 1'b0;
    logic            step_pulse_o;
    logic            key_level_o;
    logic            run_mode_o;
    logic [CntW-1:0] step_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count;

    typedef struct {
        logic            key_n;
        logic            sw_run;
        logic            pulse;
        logic            level;
        logic            run;
        logic [CntW-1:0] count;
    } vec_t;

    vec_t vecs[$];

    step_key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (8),
        .CNT_W           (CntW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_ni       (key_ni),
        .sw_run_i     (sw_run_i),
        .step_pulse_o (step_pulse_o),
        .key_level_o  (key_level_o),
        .run_mode_o   (run_mode_o),
        .step_count_o (step_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void add(logic k, logic s, logic p, logic l, logic r, int c);
        vec_t v;
        v.key_n  = k;
        v.sw_run = s;
        v.pulse  = p;
        v.level  = l;
        v.run    = r;
        v.count  = CntW'(c);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " pulse"}, int'(step_pulse_o), 0);
        check({name, " level"}, int'(key_level_o), 0);
        check({name, " run"}, int'(run_mode_o), 0);
        check({name, " count"}, int'(step_count_o), 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check_all_zero("async reset");
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // One clean press-and-release in manual mode; pulse expected on tick 7.
    task automatic press_once(input int idx);
        int ptick;
        int npulse;
        ptick  = -1;
        npulse = 0;
        key_ni = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (step_pulse_o) begin
                npulse++;
                ptick = i;
            end
        end
        key_ni = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (step_pulse_o) npulse++;
        end
        exp_count = (exp_count + 1) % 16;
        check($sformatf("press%0d pulse tick", idx), ptick, 7);
        check($sformatf("press%0d pulse count", idx), npulse, 1);
        check($sformatf("press%0d step_count", idx), int'(step_count_o), exp_count);
    endtask

    initial begin
        int npulse;
        int ptick;

        // Clean press then release.
        for (int i = 1; i <= 20; i++) add(0, 0, i == 7, i >= 7, 0, (i >= 8) ? 1 : 0);
        for (int i = 1; i <= 10; i++) add(1, 0, 0, i < 7, 0, 1);
        // Bounce rejected, then a clean hold.
        add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) add(0, 0, i == 7, i >= 7, 0, (i >= 8) ? 2 : 1);
        for (int i = 1; i <= 10; i++) add(1, 0, 0, i < 7, 0, 2);
        // Run mode with a key press that must not add a manual pulse at tick 17.
        for (int i = 1; i <= 38; i++)
            add((i >= 11 && i < 25) ? 0 : 1, 1,
                (i == 10) || (i == 18) || (i == 26) || (i == 34),
                (i >= 17 && i < 31), i >= 2,
                2 + int'(i > 10) + int'(i > 18) + int'(i > 26) + int'(i > 34));
        for (int i = 1; i <= 12; i++) add(1, 0, 0, 0, i < 2, 6);
        // Divider restarts from zero after run mode was dropped.
        for (int i = 1; i <= 12; i++) add(1, 1, i == 10, 0, i >= 2, (i >= 11) ? 7 : 6);
        for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, i < 2, 7);

        #2;
        do_reset();
        tick();
        check_all_zero("post reset");

        foreach (vecs[i]) begin
            key_ni   = vecs[i].key_n;
            sw_run_i = vecs[i].sw_run;
            tick();
            check($sformatf("vec%0d pulse", i), int'(step_pulse_o), int'(vecs[i].pulse));
            check($sformatf("vec%0d level", i), int'(key_level_o), int'(vecs[i].level));
            check($sformatf("vec%0d run", i), int'(run_mode_o), int'(vecs[i].run));
            check($sformatf("vec%0d count", i), int'(step_count_o), int'(vecs[i].count));
        end

        // Long hold then bouncy release: one pulse total, level falls 7 ticks into stable high.
        npulse = 0;
        key_ni = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (step_pulse_o) npulse++;
        end
        check("hold level", int'(key_level_o), 1);
        key_ni = 1'b1; tick(); if (step_pulse_o) npulse++;
        check("bounce1 level", int'(key_level_o), 1);
        tick(); if (step_pulse_o) npulse++;
        key_ni = 1'b0; tick(); if (step_pulse_o) npulse++;
        check("bounce3 level", int'(key_level_o), 1);
        key_ni = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (step_pulse_o) npulse++;
            check($sformatf("release tick%0d level", i), int'(key_level_o), int'(i < 7));
        end
        check("hold pulses", npulse, 1);
        check("hold count", int'(step_count_o), 8);

        // Counter wrap over 17 presses from zero.
        do_reset();
        exp_count = 0;
        for (int p = 1; p <= 17; p++) press_once(p);
        check("wrap final count", int'(step_count_o), 1);

        // Reset in S_DN_WAIT, key still held: full latency again after release.
        key_ni = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check("mid pulse", int'(step_pulse_o), 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        check_all_zero("mid first cycle");
        npulse = 0;
        ptick  = -1;
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (step_pulse_o) begin
                npulse++;
                ptick = i;
            end
        end
        check("mid pulse tick", ptick, 7);
        check("mid pulse count", npulse, 1);
        check("mid step_count", int'(step_count_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
